// File: rtl/axi_local_ram.sv
`timescale 1ns/1ps
// axi_local_ram
//   AXI4 responder in front of the DMA engine's local packet/descriptor buffer.
//   The buffer is a single-port synchronous RAM with 32-bit words. It accepts INCR bursts of up
//   to 256 beats, honours byte strobes and echoes the request ID.
//   Only one transaction is in flight at a time. Reads and writes are arbitrated round-robin.
//
// Ports
//   aclk, areset                 clock (rising edge) and asynchronous active-high reset
//   s_aw*  / s_w* / s_b*         write address, write data and write response channels
//   s_ar*  / s_r*                read address and read data channels
//   s_*size and s_*burst are ignored: every access is a 4-byte INCR access.
//
// Optional feature (macro AXI_RAM_RANGE_CHECK_EN)
//   When AXI_RAM_RANGE_CHECK_EN is defined, a burst whose start address lies at or above the
//   top of the RAM is answered with DECERR:
//     - a write burst is accepted but discarded;
//     - a read burst returns zero data.
//   When the macro is undefined, address bits above the RAM index are ignored.
module axi_local_ram #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 4096,
  parameter int ID_WIDTH    = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, WDATA = 2'd1, WRESP = 2'd2, RDATA = 2'd3} state_t;

  state_t            state;
  state_t            state_next;
  logic              prio_w;     // 1: a simultaneous AW/AR request goes to the write side
  logic [IDX_W-1:0]  idx;        // current word index, wraps naturally modulo DEPTH_WORDS
  logic [7:0]        wcnt;       // write beats remaining after the current one
  logic [8:0]        rd_rem;     // read beats not yet fetched from the RAM
  logic              err;        // sticky wlast-mismatch flag for the current write burst
  logic              oor;        // current burst started outside the RAM
  logic              aw_hs, ar_hs, w_hs, r_hs;
  logic              w_final, wlast_bad, rd_en;
  logic [31:0]       mem [DEPTH_WORDS];
  logic              unused_ok;

  assign unused_ok = ^{s_awsize, s_awburst, s_arsize, s_arburst, s_awaddr, s_araddr};

  // The address readys are held low while reset is asserted, even if a master is already
  // presenting a request.
  assign s_awready = (state == IDLE) & ~areset & s_awvalid & (~s_arvalid | prio_w);
  assign s_arready = (state == IDLE) & ~areset & s_arvalid & (~s_awvalid | ~prio_w);
  assign s_wready  = (state == WDATA);
  assign s_bvalid  = (state == WRESP);

  assign aw_hs     = s_awvalid & s_awready;
  assign ar_hs     = s_arvalid & s_arready;
  assign w_hs      = s_wvalid & s_wready;
  assign r_hs      = s_rvalid & s_rready;
  // The burst length alone ends the write burst; s_wlast only feeds the error flag.
  assign w_final   = w_hs & (wcnt == 8'd0);
  assign wlast_bad = s_wlast ^ (wcnt == 8'd0);
  // A new RAM read is issued only when the output register is empty or is being drained
  // this cycle. A stalled beat therefore freezes both the address and the enable.
  assign rd_en     = (state == RDATA) & (rd_rem != 9'd0) & (~s_rvalid | s_rready);

`ifdef AXI_RAM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] RAM_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);

  // Start-address range flag, captured together with the address at the AW/AR handshake
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      oor <= 1'b0;
    end else if (aw_hs) begin
      oor <= ({1'b0, s_awaddr} >= RAM_BYTES);
    end else if (ar_hs) begin
      oor <= ({1'b0, s_araddr} >= RAM_BYTES);
    end
  end
`else
  assign oor = 1'b0;
`endif

  // Next-state decode for the transaction FSM
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (aw_hs) state_next = WDATA;
        else if (ar_hs) state_next = RDATA;
        else state_next = IDLE;
      end
      WDATA: begin
        if (w_final) state_next = WRESP;
        else state_next = WDATA;
      end
      WRESP: begin
        if (s_bready) state_next = IDLE;
        else state_next = WRESP;
      end
      RDATA: begin
        if (r_hs && s_rlast) state_next = IDLE;
        else state_next = RDATA;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, burst bookkeeping and registered response/read-data outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      prio_w  <= 1'b1;
      idx     <= '0;
      wcnt    <= 8'd0;
      rd_rem  <= 9'd0;
      err     <= 1'b0;
      s_bid   <= '0;
      s_bresp <= 2'b00;
      s_rid   <= '0;
      s_rresp <= 2'b00;
      s_rdata <= 32'd0;
      s_rlast <= 1'b0;
      s_rvalid <= 1'b0;
    end else begin
      state <= state_next;
      if (aw_hs) begin
        prio_w <= 1'b0;
        idx    <= s_awaddr[IDX_W+1:2];
        wcnt   <= s_awlen;
        err    <= 1'b0;
        s_bid  <= s_awid;
      end else if (ar_hs) begin
        prio_w <= 1'b1;
        idx    <= s_araddr[IDX_W+1:2];
        rd_rem <= {1'b0, s_arlen} + 9'd1;
        s_rid  <= s_arid;
      end else if (w_hs) begin
        idx  <= idx + IDX_W'(1);
        wcnt <= wcnt - 8'd1;
        err  <= err | wlast_bad;
        if (w_final) begin
          s_bresp <= oor ? 2'b11 : ((err | wlast_bad) ? 2'b10 : 2'b00);
        end
      end else if (rd_en) begin
        idx    <= idx + IDX_W'(1);
        rd_rem <= rd_rem - 9'd1;
      end

      if (rd_en) begin
        s_rdata  <= oor ? 32'd0 : mem[idx];
        s_rresp  <= oor ? 2'b11 : 2'b00;
        s_rlast  <= (rd_rem == 9'd1);
        s_rvalid <= 1'b1;
      end else if (r_hs) begin
        s_rvalid <= 1'b0;
        s_rlast  <= 1'b0;
      end
    end
  end

  // RAM write port: byte-masked store of each accepted W beat (contents survive reset)
  always_ff @(posedge aclk) begin
    if (w_hs && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (s_wstrb[b]) mem[idx][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
  end
endmodule
